// File: rtl/nfc_command_feature_access.sv
`default_nettype none
// ============================================================================
// Module   : nfc_command_feature_access
// Purpose  : Sequencer that issues ONFI SET FEATURES (EFh) and GET FEATURES
//            (EEh) through the async command generator (ACG). It issues the
//            command and address cycles, streams or captures NumOfParamBytes
//            parameter bytes, and waits on the target way's ready/busy line.
//            The low-going edge of RB may be missed (RBLowWindow), and the
//            busy wait is bounded (RBTimeout).
// Ports    : iSystemClock / iReset (async, active-low)
//            Command side : iOpcode, iAddress, iWriteData, iCMDValid,
//                           iWaySelect, oCMDReady, oStart, oLastStep,
//                           oReadData, oReadValid, oTimeout
//            ACG side     : oACG_* step request, CA, write and read streams,
//                           plus iACG_Ready, iACG_LastStep and iACG_ReadyBusy
// Options  : NFC_FEATURE_VERIFY_EN -- a successful set is followed by a get
//            to the same address. oVerifyFail then flags any read-back
//            mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module nfc_command_feature_access #(
    parameter int         NumberOfWays    = 4,
    parameter logic [5:0] GetCommandID    = 6'b000101,
    parameter logic [5:0] SetCommandID    = 6'b000110,
    parameter int         NumOfParamBytes = 4,
    parameter int         RBLowWindow     = 16,
    parameter int         RBTimeout       = 65535
) (
    input  logic                          iSystemClock,
    input  logic                          iReset,
    input  logic [5:0]                    iOpcode,
    input  logic [7:0]                    iAddress,
    input  logic [8*NumOfParamBytes-1:0]  iWriteData,
    input  logic                          iCMDValid,
    output logic                          oCMDReady,
    input  logic [NumberOfWays-1:0]       iWaySelect,
    output logic                          oStart,
    output logic                          oLastStep,
    output logic [8*NumOfParamBytes-1:0]  oReadData,
    output logic                          oReadValid,
    output logic                          oTimeout,
`ifdef NFC_FEATURE_VERIFY_EN
    output logic                          oVerifyFail,
`endif
    output logic [7:0]                    oACG_Command,
    output logic [2:0]                    oACG_CommandOption,
    input  logic [7:0]                    iACG_Ready,
    input  logic [7:0]                    iACG_LastStep,
    output logic [NumberOfWays-1:0]       oACG_TargetWay,
    output logic [15:0]                   oACG_NumOfData,
    output logic                          oACG_CASelect,
    output logic [39:0]                   oACG_CAData,
    output logic [15:0]                   oACG_WriteData,
    output logic                          oACG_WriteLast,
    output logic                          oACG_WriteValid,
    input  logic                          iACG_WriteReady,
    input  logic [15:0]                   iACG_ReadData,
    input  logic                          iACG_ReadLast,
    input  logic                          iACG_ReadValid,
    output logic                          oACG_ReadReady,
    input  logic [NumberOfWays-1:0]       iACG_ReadyBusy
);

    localparam int         c_NB       = NumOfParamBytes;
    localparam int         c_DW       = 8 * NumOfParamBytes;
    localparam logic [7:0] c_GET_OPC  = 8'hEE;
    localparam logic [7:0] c_SET_OPC  = 8'hEF;
    localparam logic [7:0] c_STEP_CA  = 8'h08;
    localparam logic [7:0] c_STEP_OUT = 8'h04;
    localparam logic [7:0] c_STEP_IN  = 8'h02;

    typedef enum logic [3:0] {
        S_RESET       = 4'd0,
        S_READY       = 4'd1,
        S_CMD_LATCH   = 4'd2,
        S_CMD_ISSUE   = 4'd3,
        S_ADDR_ISSUE  = 4'd4,
        S_DATA_OUT    = 4'd5,
        S_WAIT_RB_LOW = 4'd6,
        S_WAIT_RB_HI  = 4'd7,
        S_DATA_IN     = 4'd8,
        S_DONE        = 4'd9
    } t_state;

    t_state                  r_state;
    logic                    r_get;
    logic [7:0]              r_addr;
    logic [c_DW-1:0]         r_wdata;
    logic [NumberOfWays-1:0] r_way;
    logic [7:0]              r_cmd;
    logic [3:0]              r_wbyte;
    logic                    r_wr_done;
    logic [3:0]              r_rbyte;
    logic [c_DW-1:0]         r_rbuf;
    logic [c_DW-1:0]         r_rdata;
    logic [15:0]             r_cnt;
    logic                    r_rb1;
    logic                    r_rb2;
    logic                    r_to;
    logic                    r_vphase;
    logic                    r_vfail;

    logic                    w_acg_ready;
    logic                    w_wr_valid;
    logic [7:0]              w_wr_byte;
    logic [7:0]              w_ca_byte;
    logic [c_DW-1:0]         w_rbuf_next;
    logic                    w_unused;

    // Bit 7 of the ACG ready vector does not belong to any step.
    assign w_acg_ready = &iACG_Ready[6:0];
    assign w_wr_valid  = (r_state == S_DATA_OUT) && !r_wr_done;
    assign w_wr_byte   = r_wdata[r_wbyte*8 +: 8];

    always_comb begin
        w_ca_byte = 8'h00;
        if (r_state == S_CMD_ISSUE) begin
            w_ca_byte = r_get ? c_GET_OPC : c_SET_OPC;
        end else if (r_state == S_ADDR_ISSUE) begin
            w_ca_byte = r_addr;
        end
    end

    // Merge the current read beat so that a beat arriving together with the
    // closing LastStep is still captured in the delivered word.
    always_comb begin
        w_rbuf_next = r_rbuf;
        if ((r_state == S_DATA_IN) && iACG_ReadValid && (r_rbyte < 4'(c_NB))) begin
            w_rbuf_next[r_rbyte*8 +: 8] = iACG_ReadData[7:0];
        end
    end

    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            r_state   <= S_RESET;
            r_get     <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= '0;
            r_way     <= '0;
            r_cmd     <= 8'h00;
            r_wbyte   <= 4'd0;
            r_wr_done <= 1'b0;
            r_rbyte   <= 4'd0;
            r_rbuf    <= '0;
            r_rdata   <= '0;
            r_cnt     <= 16'd0;
            r_rb1     <= 1'b0;
            r_rb2     <= 1'b0;
            r_to      <= 1'b0;
            r_vphase  <= 1'b0;
            r_vfail   <= 1'b0;
        end else begin
            // RB is asynchronous to this clock. Two register stages are used
            // before any decision is made on it.
            r_rb1  <= |(r_way & iACG_ReadyBusy);
            r_rb2  <= r_rb1;
            r_rbuf <= w_rbuf_next;
            if ((r_state == S_DATA_IN) && iACG_ReadValid && (r_rbyte < 4'(c_NB))) begin
                r_rbyte <= r_rbyte + 4'd1;
            end
            if (w_wr_valid && iACG_WriteReady) begin
                if (r_wbyte == 4'(c_NB - 1)) begin
                    r_wr_done <= 1'b1;
                end else begin
                    r_wbyte <= r_wbyte + 4'd1;
                end
            end

            case (r_state)
                S_RESET: begin
                    r_state <= S_READY;
                end
                S_READY: begin
                    r_way <= iWaySelect;
                    if (oStart) begin
                        r_get    <= (iOpcode == GetCommandID);
                        r_addr   <= iAddress;
                        r_wdata  <= iWriteData;
                        r_to     <= 1'b0;
                        r_vphase <= 1'b0;
                        r_vfail  <= 1'b0;
                        r_state  <= S_CMD_LATCH;
                    end
                end
                S_CMD_LATCH: begin
                    r_wbyte   <= 4'd0;
                    r_wr_done <= 1'b0;
                    r_rbyte   <= 4'd0;
                    r_rbuf    <= '0;
                    r_cnt     <= 16'd0;
                    r_state   <= S_CMD_ISSUE;
                end
                S_CMD_ISSUE, S_ADDR_ISSUE: begin
                    if (iACG_LastStep[3] && r_cmd[3]) begin
                        r_cmd <= 8'h00;
                        r_cnt <= 16'd0;
                        if (r_state == S_CMD_ISSUE) begin
                            r_state <= S_ADDR_ISSUE;
                        end else begin
                            r_state <= r_get ? S_WAIT_RB_LOW : S_DATA_OUT;
                        end
                    end else if ((r_cmd == 8'h00) && w_acg_ready) begin
                        r_cmd <= c_STEP_CA;
                    end
                end
                S_DATA_OUT: begin
                    if (iACG_LastStep[2] && r_cmd[2]) begin
                        r_cmd   <= 8'h00;
                        r_cnt   <= 16'd0;
                        r_state <= S_WAIT_RB_LOW;
                    end else if ((r_cmd == 8'h00) && w_acg_ready) begin
                        r_cmd <= c_STEP_OUT;
                    end
                end
                S_WAIT_RB_LOW: begin
                    // The busy period can be shorter than the sync delay. If RB
                    // never shows low, the operation is assumed to have finished.
                    if (!r_rb2 || (r_cnt == 16'(RBLowWindow - 1))) begin
                        r_cnt   <= 16'd0;
                        r_state <= S_WAIT_RB_HI;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_WAIT_RB_HI: begin
                    if (r_rb2) begin
                        if (r_get) begin
                            r_state <= S_DATA_IN;
`ifdef NFC_FEATURE_VERIFY_EN
                        end else if (!r_vphase) begin
                            // Chain a read-back of the same feature address.
                            r_vphase <= 1'b1;
                            r_get    <= 1'b1;
                            r_state  <= S_CMD_LATCH;
`endif
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (r_cnt == 16'(RBTimeout)) begin
                        r_to    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DATA_IN: begin
                    if (iACG_LastStep[1] && r_cmd[1]) begin
                        r_cmd   <= 8'h00;
                        r_rdata <= w_rbuf_next;
                        if (r_vphase) begin
                            r_vfail <= (w_rbuf_next != r_wdata);
                        end
                        r_state <= S_DONE;
                    end else if ((r_cmd == 8'h00) && w_acg_ready) begin
                        r_cmd <= c_STEP_IN;
                    end
                end
                S_DONE: begin
                    r_state <= S_READY;
                end
                default: begin
                    r_state <= S_RESET;
                end
            endcase
        end
    end

    assign oStart             = iCMDValid && ((iOpcode == GetCommandID) || (iOpcode == SetCommandID));
    assign oCMDReady          = (r_state == S_READY) || (r_state == S_RESET);
    assign oLastStep          = (r_state == S_DONE);
    assign oReadValid         = (r_state == S_DONE) && r_get && !r_to;
    assign oTimeout           = (r_state == S_DONE) && r_to;
    assign oReadData          = r_rdata;
`ifdef NFC_FEATURE_VERIFY_EN
    assign oVerifyFail        = (r_state == S_DONE) && r_vfail;
`endif

    assign oACG_Command       = r_cmd;
    assign oACG_CommandOption = 3'b000;
    assign oACG_TargetWay     = r_way;
    assign oACG_NumOfData     = ((r_state == S_DATA_OUT) || (r_state == S_DATA_IN)) ? 16'(c_NB) : 16'd0;
    assign oACG_CASelect      = (r_state != S_ADDR_ISSUE);
    assign oACG_CAData        = {w_ca_byte, 32'h0000_0000};
    assign oACG_WriteValid    = w_wr_valid;
    assign oACG_WriteData     = w_wr_valid ? {8'h00, w_wr_byte} : 16'h0000;
    assign oACG_WriteLast     = w_wr_valid && (r_wbyte == 4'(c_NB - 1));
    assign oACG_ReadReady     = (r_state == S_DATA_IN);

    // Interface bits that this sequencer has no use for.
    assign w_unused = &{1'b0, iACG_Ready[7], iACG_LastStep[7:4], iACG_LastStep[0],
                        iACG_ReadData[15:8], iACG_ReadLast};

endmodule
`default_nettype wire
